pool_sequencer: RTL and testbench

Frame-level controller for the cascaded 2x2 max-pooling chain.
- On a host `start` it sweeps the frame coordinate counters that drive the `stream_patch`/pooling stages.
- It reconstructs, per pooling level, the strobe marking a valid pooled sample at that level's pipeline depth.
- After the pipeline drains it reports frame completion.
- It sits between the frame source/host and the first pooling stage and replaces the per-stage ad-hoc enable decoding.

---
 rtl/pool_pkg.sv | 39 +++
 rtl/delay.sv | 41 ++++
 rtl/pool_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pool_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// pool_pkg
//   Shared definitions for the pooling-chain frame sequencer:
//   - state encoding for the frame FSM
//   - ceil-log2 helper and the derived counter widths
//   - flush length and per-level tap masks
package pool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // ceil(log2(n)); 0 for n <= 1
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Counter width for a range of n values, never narrower than one bit
  function automatic int bitw(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Drain time of the whole cascade
  function automatic int flush_len(input int levels, input int lat);
    return levels * lat;
  endfunction

  // Low (lvl+1) bits set: a level-lvl pooled sample closes when both
  // coordinates have all these bits set.
  function automatic logic [31:0] tap_mask(input int lvl);
    return (32'd1 << (lvl + 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/delay.sv
// delay
//   Fixed-latency shift register with a synchronous clear.
//   Ports:
//     clock  - clock
//     rst    - asynchronous active-high reset, clears every stage
//     clr    - synchronous clear of every stage (frame abort)
//     din    - input word
//     dout   - din delayed by LATENCY cycles (registered)
module delay
  #(
    parameter int BIT_WIDTH = 1,
    parameter int LATENCY   = 1
  ) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [BIT_WIDTH-1:0] din,
    output logic [BIT_WIDTH-1:0] dout
  );

  logic [BIT_WIDTH-1:0] stage_q [LATENCY];
  logic [BIT_WIDTH-1:0] stage_d [LATENCY];

  always_comb begin
    stage_d[0] = clr ? '0 : din;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = clr ? '0 : stage_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign dout = stage_q[LATENCY-1];

endmodule

// File: rtl/pool_sequencer.sv
// pool_sequencer
//   Frame-level controller for the cascaded 2x2 max-pooling chain. Sweeps
//   the frame coordinates after a start, drains the pipeline, pulses done,
//   and regenerates the per-level valid strobe at each level's depth.
//   Ports:
//     clock      - clock
//     rst        - asynchronous active-high reset
//     start      - frame request, taken only when idle
//     abort      - cancel current frame (RUN/FLUSH only)
//     in_valid   - source pixel strobe, checked on active coordinates
//     busy       - high while sweeping or draining
//     done       - one-cycle completion pulse
//     frame_err  - sticky underrun flag, cleared by an accepted start
//     out_enable - pixel enable to the pooling chain
//     out_vcnt   - frame row
//     out_hcnt   - frame column
//     lvl_valid  - bit L: pooling level L presents a valid sample
module pool_sequencer
  import pool_pkg::*;
  #(
    parameter int WIDTH        = 8,
    parameter int HEIGHT       = 8,
    parameter int W_WIDTH      = 16,
    parameter int W_HEIGHT     = 16,
    parameter int LEVELS       = 2,
    parameter int PIPE_LATENCY = 4
  ) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         frame_err,
    output logic                         out_enable,
    output logic [bitw(W_HEIGHT)-1:0]    out_vcnt,
    output logic [bitw(W_WIDTH)-1:0]     out_hcnt,
    output logic [LEVELS-1:0]            lvl_valid
  );

  localparam int V_BITW  = bitw(W_HEIGHT);
  localparam int H_BITW  = bitw(W_WIDTH);
  localparam int F       = flush_len(LEVELS, PIPE_LATENCY);
  localparam int FC_BITW = bitw(F + 1);

  state_t              state_q, state_d;
  logic [H_BITW-1:0]   hcnt_q, hcnt_d;
  logic [V_BITW-1:0]   vcnt_q, vcnt_d;
  logic [FC_BITW-1:0]  flush_q, flush_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                out_enable_q, out_enable_d;
  logic                clr_lines;
  logic                active;
  logic                h_last, v_last;
  logic [LEVELS-1:0]   tap;

  assign active = (32'(vcnt_q) < HEIGHT) && (32'(hcnt_q) < WIDTH);
  assign h_last = (hcnt_q == H_BITW'(W_WIDTH - 1));
  assign v_last = (vcnt_q == V_BITW'(W_HEIGHT - 1));

  // Next-state, counters and underrun tracking
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    flush_d     = flush_q;
    frame_err_d = frame_err_q;
    clr_lines   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // start beats a simultaneous abort; abort is meaningless here
        if (start) begin
          state_d     = ST_RUN;
          frame_err_d = 1'b0;
          hcnt_d      = '0;
          vcnt_d      = '0;
        end
      end

      ST_RUN: begin
        // A missing pixel on an active coordinate is remembered even if
        // the frame is aborted in the same cycle.
        if (active && !in_valid) frame_err_d = 1'b1;

        if (abort) begin
          state_d   = ST_IDLE;
          hcnt_d    = '0;
          vcnt_d    = '0;
          clr_lines = 1'b1;
        end else if (h_last) begin
          hcnt_d = '0;
          if (v_last) begin
            vcnt_d  = '0;
            state_d = ST_FLUSH;
            flush_d = FC_BITW'(F);
          end else begin
            vcnt_d = vcnt_q + V_BITW'(1);
          end
        end else begin
          hcnt_d = hcnt_q + H_BITW'(1);
        end
      end

      ST_FLUSH: begin
        if (abort) begin
          state_d   = ST_IDLE;
          flush_d   = '0;
          clr_lines = 1'b1;
        end else if (flush_q == FC_BITW'(1)) begin
          state_d = ST_DONE;
          flush_d = '0;
        end else begin
          flush_d = flush_q - FC_BITW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so they leave flops
    busy_d       = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    done_d       = (state_d == ST_DONE);
    out_enable_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      flush_q      <= '0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      flush_q      <= flush_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      out_enable_q <= out_enable_d;
    end
  end

  // Per-level tap: the coordinate closing a 2^(L+1) square window, delayed
  // by the cumulative pipeline depth of levels 0..L.
  genvar gi;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_level
      assign tap[gi] = out_enable_q && active &&
                       ((32'(hcnt_q) & tap_mask(gi)) == tap_mask(gi)) &&
                       ((32'(vcnt_q) & tap_mask(gi)) == tap_mask(gi));

      delay #(
        .BIT_WIDTH (1),
        .LATENCY   ((gi + 1) * PIPE_LATENCY)
      ) u_delay (
        .clock (clock),
        .rst   (rst),
        .clr   (clr_lines),
        .din   (tap[gi]),
        .dout  (lvl_valid[gi])
      );
    end
  endgenerate

  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_err  = frame_err_q;
  assign out_enable = out_enable_q;
  assign out_vcnt   = vcnt_q;
  assign out_hcnt   = hcnt_q;

endmodule

// File: tb/tb_pool_sequencer.sv
// tb_pool_sequencer
//   Directed frames against hand-computed cycle positions for the default
//   geometry (8x8 active, 16x16 total, 2 levels of latency 4, flush 8).
module tb_pool_sequencer;

  logic       clock;
  logic       rst;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic       busy;
  logic       done;
  logic       frame_err;
  logic       out_enable;
  logic [3:0] out_vcnt;
  logic [3:0] out_hcnt;
  logic [1:0] lvl_valid;

  int n_vec;
  int n_bad;

  // per-frame observations, k = cycles after the start cycle
  int busy_first, busy_last, done_cnt, done_at;
  int l0_cnt, l1_cnt, l0_first, l1_first, l1_last;
  int err_first, err_at_done, lvl_after_abort;
  int v_at_38, h_at_38, en_at_1;

  pool_sequencer dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .busy       (busy),
    .done       (done),
    .frame_err  (frame_err),
    .out_enable (out_enable),
    .out_vcnt   (out_vcnt),
    .out_hcnt   (out_hcnt),
    .lvl_valid  (lvl_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One frame: start (optionally with abort), then observe for stop_k cycles.
  // drop_k/abort_k/restart_k pick the cycle where in_valid drops, abort
  // fires, or a stray start is issued (0 = never).
  task automatic run_frame(input string name, input int drop_k, input int abort_k,
                           input int restart_k, input bit abort_at_start,
                           input int stop_k);
    busy_first = 0; busy_last = 0; done_cnt = 0; done_at = 0;
    l0_cnt = 0; l1_cnt = 0; l0_first = 0; l1_first = 0; l1_last = 0;
    err_first = 0; err_at_done = 0; lvl_after_abort = 0;
    v_at_38 = -1; h_at_38 = -1; en_at_1 = 0;

    start = 1'b1;
    abort = abort_at_start;
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;

    for (int k = 1; k <= stop_k; k++) begin
      if (busy) begin
        if (busy_first == 0) busy_first = k;
        busy_last = k;
      end
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
        err_at_done = int'(frame_err);
      end
      if (lvl_valid[0]) begin
        l0_cnt++;
        if (l0_first == 0) l0_first = k;
      end
      if (lvl_valid[1]) begin
        l1_cnt++;
        if (l1_first == 0) l1_first = k;
        l1_last = k;
      end
      if (frame_err && err_first == 0) err_first = k;
      if (abort_k > 0 && k > abort_k && lvl_valid != 2'b00) lvl_after_abort++;
      if (k == 1) en_at_1 = int'(out_enable);
      if (k == 38) begin
        v_at_38 = int'(out_vcnt);
        h_at_38 = int'(out_hcnt);
      end

      in_valid = (k != drop_k);
      abort    = (k == abort_k);
      start    = (k == restart_k);
      tick();
    end
    in_valid = 1'b1;
    abort    = 1'b0;
    start    = 1'b0;
    $display("frame %s: busy %0d..%0d done=%0d@%0d lvl0=%0d lvl1=%0d err@%0d",
             name, busy_first, busy_last, done_cnt, done_at, l0_cnt, l1_cnt, err_first);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset state
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_err", int'(frame_err), 0);
    check_val("rst_en", int'(out_enable), 0);
    check_val("rst_vcnt", int'(out_vcnt), 0);
    check_val("rst_hcnt", int'(out_hcnt), 0);
    check_val("rst_lvl", int'(lvl_valid), 0);

    // nominal frame
    run_frame("nominal", 0, 0, 0, 1'b0, 270);
    check_val("nom_en_at_1", en_at_1, 1);
    check_val("nom_busy_first", busy_first, 1);
    check_val("nom_busy_last", busy_last, 264);
    check_val("nom_done_cnt", done_cnt, 1);
    check_val("nom_done_at", done_at, 265);
    check_val("nom_lvl0_cnt", l0_cnt, 16);
    check_val("nom_lvl1_cnt", l1_cnt, 4);
    check_val("nom_lvl0_first", l0_first, 22);
    check_val("nom_lvl1_first", l1_first, 60);
    check_val("nom_lvl1_last", l1_last, 128);
    check_val("nom_vcnt_38", v_at_38, 2);
    check_val("nom_hcnt_38", h_at_38, 5);
    check_val("nom_err", err_first, 0);

    // underrun at (2,5) = k 38
    run_frame("underrun", 38, 0, 0, 1'b0, 270);
    check_val("ur_err_first", err_first, 39);
    check_val("ur_err_at_done", err_at_done, 1);
    check_val("ur_done_at", done_at, 265);

    // drop only in blanking at (2,12) = k 45; start clears the old error
    run_frame("blank_drop", 45, 0, 0, 1'b0, 270);
    check_val("bd_err_first", err_first, 0);
    check_val("bd_done_at", done_at, 265);

    // abort at (5,3) = k 84
    run_frame("abort", 0, 84, 0, 1'b0, 270);
    check_val("ab_busy_last", busy_last, 84);
    check_val("ab_done_cnt", done_cnt, 0);
    check_val("ab_lvl_after", lvl_after_abort, 0);
    check_val("ab_en_idle", int'(out_enable), 0);

    run_frame("after_abort", 0, 0, 0, 1'b0, 270);
    check_val("aa_lvl0_cnt", l0_cnt, 16);
    check_val("aa_lvl1_cnt", l1_cnt, 4);
    check_val("aa_done_cnt", done_cnt, 1);
    check_val("aa_done_at", done_at, 265);

    // stray start during RUN is ignored
    run_frame("start_in_run", 0, 0, 100, 1'b0, 280);
    check_val("sr_done_cnt", done_cnt, 1);
    check_val("sr_done_at", done_at, 265);
    check_val("sr_busy_last", busy_last, 264);

    // start and abort together in IDLE: frame begins
    run_frame("start_abort", 0, 0, 0, 1'b1, 270);
    check_val("sa_en_at_1", en_at_1, 1);
    check_val("sa_busy_first", busy_first, 1);
    check_val("sa_done_at", done_at, 265);

    // asynchronous reset during FLUSH (k 261)
    run_frame("rst_flush", 0, 0, 0, 1'b0, 260);
    check_val("rf_busy_pre", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("rf_busy", int'(busy), 0);
    check_val("rf_done", int'(done), 0);
    check_val("rf_en", int'(out_enable), 0);
    check_val("rf_lvl", int'(lvl_valid), 0);
    check_val("rf_vcnt", int'(out_vcnt), 0);
    check_val("rf_hcnt", int'(out_hcnt), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_val("rf_idle_busy", int'(busy), 0);
    check_val("rf_idle_done", int'(done), 0);
    check_val("rf_idle_en", int'(out_enable), 0);

    run_frame("post_reset", 0, 0, 0, 1'b0, 270);
    check_val("pr_done_at", done_at, 265);
    check_val("pr_lvl0_cnt", l0_cnt, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
